dmem_mmio_bridge: RTL and testbench

Sits between the core's data-memory port and the data RAM, splitting core accesses into RAM traffic and a small memory-mapped I/O window. The window holds a byte TX FIFO drained over a valid/ready stream, a status register, an optional free-running cycle counter and a TOHOST halt register used by benches and the console path. Reads return in the same cycle, because the single-cycle core consumes `dmem_rdata` combinationally. Writes commit on the clock edge.

---
 rtl/dmem_mmio_bridge.sv | 186 ++++++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge.sv
// Splits core data-memory accesses between the data RAM and a 16-byte MMIO window
// (TX byte FIFO, status, cycle counter, TOHOST halt). Define CYCLE_COUNTER_EN to build the counter.
module dmem_mmio_bridge #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DADDR      = 16,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [DADDR-1:0] MMIO_BASE  = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic [DADDR-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_wr_en,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             halt,
  output logic [WIDTH-1:0] exit_code
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffCycle  = 2'd2;
  localparam logic [1:0] OffToHost = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             halt_q, halt_d;
  logic [WIDTH-1:0] exit_code_q, exit_code_d;

  logic             mmio_hit;
  logic [1:0]       offset;
  logic             mmio_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] cycle_val;
  logic             unused_addr_lo;

  assign mmio_hit       = (dmem_addr[DADDR-1:4] == MMIO_BASE[DADDR-1:4]);
  assign offset         = dmem_addr[3:2];
  assign unused_addr_lo = ^dmem_addr[1:0];

  // Every MMIO side effect is gated by halt; only reads stay live afterwards.
  assign mmio_wr    = mmio_hit & dmem_wr_en & ~halt_q;
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & tx_ready;
  assign push_req   = mmio_wr & (offset == OffTxData);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push       = push_req & (~fifo_full | pop);

  assign ram_addr  = dmem_addr;
  assign ram_wdata = dmem_wdata;
  assign ram_wr_en = dmem_wr_en & ~mmio_hit & ~halt_q;

  assign tx_valid  = ~fifo_empty;
  assign tx_data   = mem_q[rd_ptr_q];
  assign halt      = halt_q;
  assign exit_code = exit_code_q;

`ifdef CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q;
    if (!halt_q) begin
      cycle_d = cycle_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    halt_d      = halt_q;
    exit_code_d = exit_code_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (mmio_wr) begin
      case (offset)
        OffTxData: begin
          if (fifo_full && !pop) begin
            ovf_d = 1'b1;
          end
        end
        OffStatus: begin
          if (dmem_wdata[2]) begin
            ovf_d = 1'b0;
          end
        end
        OffToHost: begin
          halt_d      = 1'b1;
          exit_code_d = dmem_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dmem_wdata[7:0];
      end
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = fifo_full;
    status[1]       = fifo_empty;
    status[2]       = ovf_q;
    status[8+:CntW] = count_q;
  end

  // Same-cycle read path: the core consumes dmem_rdata combinationally.
  always_comb begin
    dmem_rdata = ram_rdata;
    if (mmio_hit) begin
      case (offset)
        OffTxData: dmem_rdata = '0;
        OffStatus: dmem_rdata = status;
        OffCycle:  dmem_rdata = cycle_val;
        OffToHost: dmem_rdata = exit_code_q;
        default:   dmem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge: directed scenarios plus random traffic checked against a
// queue-based model of the MMIO window and RAM.
module tb_dmem_mmio_bridge;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [11:0] BASE_HI    = 12'hFF0;
  localparam logic [15:0] A_TX       = 16'hFF00;
  localparam logic [15:0] A_STATUS   = 16'hFF04;
  localparam logic [15:0] A_CYCLE    = 16'hFF08;
  localparam logic [15:0] A_TOHOST   = 16'hFF0C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_wr_en = 1'b0;
  logic [31:0] dmem_rdata;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wr_en;
  logic [31:0] ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  mq[$];
  logic        m_ovf;
  logic        m_halt;
  logic [31:0] m_exit;
  logic [31:0] m_cycle;
  logic [31:0] m_ram [256];

  // Environment RAM, written only through the DUT's RAM port.
  logic [31:0] tb_ram [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) tb_ram[i] <= '0;
    end else if (ram_wr_en) begin
      tb_ram[ram_addr[9:2]] <= ram_wdata;
    end
  end

  assign ram_rdata = tb_ram[ram_addr[9:2]];

  dmem_mmio_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wr_en (dmem_wr_en),
    .dmem_rdata (dmem_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wr_en  (ram_wr_en),
    .ram_rdata  (ram_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .exit_code  (exit_code)
  );

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_halt  = 1'b0;
    m_exit  = '0;
    m_cycle = '0;
    for (int i = 0; i < 256; i++) m_ram[i] = '0;
  endtask

  function automatic logic is_hit(input logic [15:0] a);
    return a[15:4] == BASE_HI;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [15:0] a);
    logic [31:0] r;
    r = '0;
    if (!is_hit(a)) return m_ram[a[9:2]];
    case (a[3:2])
      2'd1: begin
        r[0]    = (mq.size() == FIFO_DEPTH);
        r[1]    = (mq.size() == 0);
        r[2]    = m_ovf;
        r[15:8] = 8'(mq.size());
      end
`ifdef CYCLE_COUNTER_EN
      2'd2: r = m_cycle;
`endif
      2'd3: r = m_exit;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock cycle with the currently driven inputs; returns at the next falling edge.
  task automatic tick();
    logic pop, full, halted, push;
    @(posedge clk);
    pop    = (mq.size() != 0) && tx_ready;
    full   = (mq.size() == FIFO_DEPTH);
    halted = m_halt;
    push   = 1'b0;
    if (!halted) m_cycle = m_cycle + 32'd1;
    if (dmem_wr_en && !halted) begin
      if (!is_hit(dmem_addr)) begin
        m_ram[dmem_addr[9:2]] = dmem_wdata;
      end else begin
        case (dmem_addr[3:2])
          2'd0: if (!full || pop) push = 1'b1; else m_ovf = 1'b1;
          2'd1: if (dmem_wdata[2]) m_ovf = 1'b0;
          2'd3: begin m_halt = 1'b1; m_exit = dmem_wdata; end
          default: ;
        endcase
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(dmem_wdata[7:0]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dmem_addr = 16'h0100; dmem_wdata = '0; dmem_wr_en = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt); end
    checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL reset_exit: got %h want 0", exit_code); end
    dmem_addr = A_STATUS; #1;
    checks++; if (dmem_rdata !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 2", dmem_rdata); end
    dmem_addr = 16'h0100; dmem_wr_en = 1'b1; #1;
    checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL reset_ram_wr_en: got %b want 1", ram_wr_en); end
    dmem_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tx_order();
    logic [7:0] b;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dmem_addr = A_TX; dmem_wdata = 32'h41 + 32'(i); dmem_wr_en = 1'b1;
      tick();
    end
    dmem_wr_en = 1'b0; dmem_addr = A_STATUS; #1;
    checks++; if (dmem_rdata !== 32'h0000_0300) begin errors++; $display("FAIL order_status: got %h want 00000300", dmem_rdata); end
    checks++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin errors++; $display("FAIL order_head: got %b/%h want 1/41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'h41 + 8'(i);
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== b) begin errors++; $display("FAIL order_stream%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, b); end
      tick();
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dmem_addr = A_TX; dmem_wdata = 32'(i + 1); dmem_wr_en = 1'b1;
      tick();
    end
    dmem_wdata = 32'h99;
    tick();
    dmem_wr_en = 1'b0; dmem_addr = A_STATUS; #1;
    checks++; if (dmem_rdata !== 32'h0000_0805) begin errors++; $display("FAIL ovf_status: got %h want 00000805", dmem_rdata); end
    checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h want 01", tx_data); end
    dmem_wdata = 32'h4; dmem_wr_en = 1'b1;
    tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (dmem_rdata !== 32'h0000_0801) begin errors++; $display("FAIL ovf_clear: got %h want 00000801", dmem_rdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    dmem_addr = A_TX; dmem_wdata = 32'hAB; dmem_wr_en = 1'b1; tx_ready = 1'b1; #1;
    checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL fpp_head: got %h want 01", tx_data); end
    tick();
    dmem_wr_en = 1'b0; tx_ready = 1'b0; dmem_addr = A_STATUS; #1;
    checks++; if (dmem_rdata !== 32'h0000_0801) begin errors++; $display("FAIL fpp_status: got %h want 00000801", dmem_rdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = (i < 7) ? 8'(i + 2) : 8'hAB;
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== b) begin errors++; $display("FAIL fpp_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, b); end
      tick();
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_ram();
    dmem_addr = 16'h0100; dmem_wdata = 32'h1234; dmem_wr_en = 1'b1; #1;
    checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL ram_wr_en: got %b want 1", ram_wr_en); end
    checks++; if (ram_addr !== 16'h0100 || ram_wdata !== 32'h1234) begin errors++; $display("FAIL ram_pass: got %h/%h want 0100/00001234", ram_addr, ram_wdata); end
    tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL ram_wr_idle: got %b want 0", ram_wr_en); end
    checks++; if (dmem_rdata !== 32'h1234) begin errors++; $display("FAIL ram_read: got %h want 00001234", dmem_rdata); end
    dmem_addr = 16'hFF10; dmem_wdata = 32'hCAFE; dmem_wr_en = 1'b1; #1;
    checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL ram_edge_wr: got %b want 1", ram_wr_en); end
    tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (dmem_rdata !== 32'hCAFE) begin errors++; $display("FAIL ram_edge_read: got %h want 0000cafe", dmem_rdata); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [31:0] er;
    logic        ew;
    int unsigned r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) a = 16'h0100 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
      else if (r < 8) a = A_TX + 16'($urandom_range(0, 3));
      else a = A_STATUS + 16'($urandom_range(0, 11));
      dmem_addr  = a;
      dmem_wdata = $urandom;
      dmem_wr_en = 1'($urandom_range(0, 1));
      if (is_hit(a) && a[3:2] == 2'd3) dmem_wr_en = 1'b0;
      tx_ready = (n < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      er = exp_rd(a);
      ew = !is_hit(a) && dmem_wr_en && !m_halt;
      #1;
      checks++; if (dmem_rdata !== er) begin errors++; $display("FAIL rnd_rdata@%0d addr %h: got %h want %h", n, a, dmem_rdata, er); end
      checks++; if (ram_wr_en !== ew) begin errors++; $display("FAIL rnd_ram_wr_en@%0d: got %b want %b", n, ram_wr_en, ew); end
      checks++; if (tx_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_tx_valid@%0d: got %b want %b", n, tx_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (tx_data !== mq[0]) begin errors++; $display("FAIL rnd_tx_data@%0d: got %h want %h", n, tx_data, mq[0]); end
      end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rnd_halt@%0d: got %b want 0", n, halt); end
      tick();
    end
    dmem_wr_en = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic test_cycle();
    logic [31:0] v0;
    dmem_addr = A_CYCLE; dmem_wr_en = 1'b0; #1;
    v0 = dmem_rdata;
`ifdef CYCLE_COUNTER_EN
    checks++; if (v0 !== m_cycle) begin errors++; $display("FAIL cycle_value: got %h want %h", v0, m_cycle); end
`else
    checks++; if (v0 !== 32'h0) begin errors++; $display("FAIL cycle_zero: got %h want 0", v0); end
`endif
    repeat (10) tick();
    #1;
`ifdef CYCLE_COUNTER_EN
    checks++; if (dmem_rdata - v0 !== 32'd10) begin errors++; $display("FAIL cycle_delta: got %0d want 10", dmem_rdata - v0); end
`else
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL cycle_zero2: got %h want 0", dmem_rdata); end
`endif
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0; dmem_addr = A_TX; dmem_wr_en = 1'b1;
    dmem_wdata = 32'h5A; tick();
    dmem_wdata = 32'h5B; tick();
    dmem_wr_en = 1'b0; dmem_addr = A_STATUS; #1;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", tx_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx: got %b/%h want 0/00", tx_valid, tx_data); end
    checks++; if (dmem_rdata !== 32'h2) begin errors++; $display("FAIL mid_status: got %h want 2", dmem_rdata); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    tx_ready = 1'b0; dmem_addr = A_TX; dmem_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dmem_wdata = 32'h11 * 32'(i + 1);
      tick();
    end
    dmem_addr = A_TOHOST; dmem_wdata = 32'd7; tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (halt !== 1'b1 || exit_code !== 32'd7) begin errors++; $display("FAIL halt_set: got %b/%h want 1/7", halt, exit_code); end
    checks++; if (dmem_rdata !== 32'd7) begin errors++; $display("FAIL halt_tohost_rd: got %h want 7", dmem_rdata); end
    dmem_wdata = 32'd9; dmem_wr_en = 1'b1; tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (exit_code !== 32'd7) begin errors++; $display("FAIL halt_second: got %h want 7", exit_code); end
    dmem_addr = 16'h0104; dmem_wdata = 32'hDEAD; dmem_wr_en = 1'b1; #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL halt_ram_blk: got %b want 0", ram_wr_en); end
    tick();
    dmem_wr_en = 1'b0; #1;
    checks++; if (dmem_rdata !== exp_rd(16'h0104)) begin errors++; $display("FAIL halt_ram_rd: got %h want %h", dmem_rdata, exp_rd(16'h0104)); end
    dmem_addr = A_TX; dmem_wdata = 32'h77; dmem_wr_en = 1'b1; tick();
    dmem_wr_en = 1'b0; dmem_addr = A_STATUS; #1;
    checks++; if (dmem_rdata !== 32'h0000_0300) begin errors++; $display("FAIL halt_push_blk: got %h want 00000300", dmem_rdata); end
    dmem_addr = A_CYCLE; #1;
    c0 = dmem_rdata;
`ifdef CYCLE_COUNTER_EN
    checks++; if (c0 !== m_cycle) begin errors++; $display("FAIL halt_cycle: got %h want %h", c0, m_cycle); end
`endif
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL halt_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(8'h11 * (i + 1))); end
      tick();
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL halt_drain_end: got %b want 0", tx_valid); end
`ifdef CYCLE_COUNTER_EN
    checks++; if (dmem_rdata !== c0) begin errors++; $display("FAIL halt_cycle_frozen: got %h want %h", dmem_rdata, c0); end
`else
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL halt_cycle_zero: got %h want 0", dmem_rdata); end
`endif
    tx_ready = 1'b0;
    reset = 1'b1; #1;
    checks++; if (halt !== 1'b0 || exit_code !== 32'h0) begin errors++; $display("FAIL halt_reset: got %b/%h want 0/0", halt, exit_code); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tx_order();
    test_overflow();
    test_full_push_pop();
    test_ram();
    test_random();
    test_cycle();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
